// File: rtl/toggle_hs_rx_pkg.sv
// rtl/toggle_hs_rx_pkg.sv - shared types and defaults for the toggle handshake receiver
package toggle_hs_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 16;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Two-phase protocol: a request is outstanding whenever the levels differ.
   function automatic logic req_pending(input logic req_s, input logic ack);
      return req_s ^ ack;
   endfunction

endpackage

// File: rtl/toggle_hs_rx_if.sv
// rtl/toggle_hs_rx_if.sv - toggle request link plus valid/ready output port
interface toggle_hs_rx_if
   import toggle_hs_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic              req_tgl;
   logic [DATA_W-1:0] data_in;
   logic              ack_tgl;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport master (
      output req_tgl, data_in, out_ready,
      input  ack_tgl, out_valid, out_data
   );

   modport slave (
      input  req_tgl, data_in, out_ready,
      output ack_tgl, out_valid, out_data
   );
endinterface

// File: rtl/toggle_hs_rx_bit_sync.sv
// rtl/toggle_hs_rx_bit_sync.sv - multi-flop single-bit synchronizer
module bit_sync
   import toggle_hs_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
)(
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - receive side of a two-phase toggle request/acknowledge crossing
module toggle_hs_rx
   import toggle_hs_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             rst,
   toggle_hs_rx_if.slave    io_link,
   input  logic             i_err_clr,
   output logic [CNT_W-1:0] o_xfer_cnt,
   output logic             o_proto_err
);
   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("toggle_hs_rx: SYNC_STAGES outside legal range");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_ack;
   logic [DATA_W-1:0] r_out_data;
   logic [CNT_W-1:0]  r_xfer_cnt;
   logic              r_proto_err;

   logic w_req_s;
   logic w_pending;
   logic w_out_valid;
   logic w_capture;
   logic w_handshake;
   logic w_violation;

   bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst (rst),
      .i_d (io_link.req_tgl),
      .o_q (w_req_s)
   );

   assign w_pending = req_pending(w_req_s, r_ack);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pending)         w_state_nxt = VALID;
         VALID:   if (io_link.out_ready) w_state_nxt = IDLE;
         default:                        w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_out_valid = 1'b0;
      w_capture   = 1'b0;
      w_handshake = 1'b0;
      w_violation = 1'b0;
      case (r_state)
         IDLE: begin
            w_capture = w_pending;
         end
         VALID: begin
            w_out_valid = 1'b1;
            w_handshake = io_link.out_ready;
            // Sender flipped again before our ack: levels re-matched while a word is held.
            w_violation = ~w_pending;
         end
         default: begin
            w_out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack       <= 1'b0;
         r_out_data  <= '0;
         r_xfer_cnt  <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_capture) r_out_data <= io_link.data_in;
         if (w_handshake) begin
            r_ack      <= ~r_ack;
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
         end
         if (w_violation)    r_proto_err <= 1'b1;
         else if (i_err_clr) r_proto_err <= 1'b0;
      end
   end

   assign io_link.ack_tgl   = r_ack;
   assign io_link.out_valid = w_out_valid;
   assign io_link.out_data  = r_out_data;
   assign o_xfer_cnt        = r_xfer_cnt;
   assign o_proto_err       = r_proto_err;
endmodule
